// File: rtl/ssd_scan_decoder.sv
// Recovers the four digits shown on a multiplexed 7-segment display by
// debouncing the scanned anode/segment lines and assembling complete frames.
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digit_value,
    output logic [13:0] time_value,
    output logic        frame_valid,
    output logic        seg_error,
    output logic        an_error
);

    localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    logic [3:0]  an_reg, an_prev_reg;
    logic [6:0]  seg_reg, seg_prev_reg;
    logic [7:0]  cnt_reg, cnt_next;
    logic [3:0]  mask_reg, mask_next;
    logic [15:0] slots_reg;
    logic [15:0] digit_value_reg;
    logic [13:0] time_value_reg, time_calc;
    logic        frame_valid_reg, seg_error_reg, an_error_reg;

    logic        changed, accept, an_blank, an_onehot, an_multi;
    logic        dec_valid, capture, frame_done;
    logic [3:0]  dec_nibble, an_low, slot_we;

    // The previous-cycle sample is what a full stable window has held,
    // so it is the value that gets decoded on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg       <= 4'b1111;
            seg_reg      <= 7'b1111111;
            an_prev_reg  <= 4'b1111;
            seg_prev_reg <= 7'b1111111;
            cnt_reg      <= 8'd0;
        end else begin
            an_reg       <= an;
            seg_reg      <= seg;
            an_prev_reg  <= an_reg;
            seg_prev_reg <= seg_reg;
            cnt_reg      <= cnt_next;
        end
    end

    assign changed = {an_reg, seg_reg} != {an_prev_reg, seg_prev_reg};

    always_comb begin
        cnt_next = cnt_reg;
        if (changed)
            cnt_next = 8'd0;
        else if (cnt_reg != STABLE_MAX)
            cnt_next = cnt_reg + 8'd1;
    end

    // Counter saturates above STABLE_LAST, so this fires once per window.
    assign accept    = (cnt_reg == STABLE_LAST);
    assign an_low    = ~an_prev_reg;
    assign an_blank  = (an_low == 4'b0000);
    assign an_onehot = $onehot(an_low);
    assign an_multi  = !an_blank && !an_onehot;

    always_comb begin
        dec_valid  = 1'b1;
        dec_nibble = 4'd0;
        case (seg_prev_reg)
            7'b1000000: dec_nibble = 4'd0;
            7'b1111001: dec_nibble = 4'd1;
            7'b0100100: dec_nibble = 4'd2;
            7'b0110000: dec_nibble = 4'd3;
            7'b0011001: dec_nibble = 4'd4;
            7'b0010010: dec_nibble = 4'd5;
            7'b0000010: dec_nibble = 4'd6;
            7'b1111000: dec_nibble = 4'd7;
            7'b0000000: dec_nibble = 4'd8;
            7'b0010000: dec_nibble = 4'd9;
            default:    dec_valid  = 1'b0;
        endcase
    end

    assign capture    = accept && an_onehot && dec_valid;
    assign frame_done = (mask_reg == 4'b1111);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot_we
            assign slot_we[gi] = capture && an_low[gi];
        end
    endgenerate

    always_comb begin
        mask_next = mask_reg;
        if (frame_done)
            mask_next = 4'b0000;
        else if (accept && (an_multi || (an_onehot && !dec_valid)))
            mask_next = 4'b0000;
        else if (capture)
            mask_next = mask_reg | an_low;
    end

    always_comb begin
        time_calc = 14'(slots_reg[15:12]) * 14'd1000
                  + 14'(slots_reg[11:8])  * 14'd100
                  + 14'(slots_reg[7:4])   * 14'd10
                  + 14'(slots_reg[3:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg        <= 4'b0000;
            slots_reg       <= 16'h0000;
            digit_value_reg <= 16'h0000;
            time_value_reg  <= 14'd0;
            frame_valid_reg <= 1'b0;
            seg_error_reg   <= 1'b0;
            an_error_reg    <= 1'b0;
        end else begin
            mask_reg <= mask_next;
            for (int i = 0; i < 4; i++) begin
                if (slot_we[i])
                    slots_reg[4*i +: 4] <= dec_nibble;
            end
            if (frame_done) begin
                digit_value_reg <= slots_reg;
                time_value_reg  <= time_calc;
            end
            frame_valid_reg <= frame_done;
            seg_error_reg   <= accept && an_onehot && !dec_valid;
            an_error_reg    <= accept && an_multi;
        end
    end

    assign digit_value = digit_value_reg;
    assign time_value  = time_value_reg;
    assign frame_valid = frame_valid_reg;
    assign seg_error   = seg_error_reg;
    assign an_error    = an_error_reg;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops
// and compares them whenever the decoder raises a pulse.
module tb_ssd_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digit_value;
    logic [13:0] time_value;
    logic        frame_valid, seg_error, an_error;

    ssd_scan_decoder #(.STABLE_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .digit_value (digit_value),
        .time_value  (time_value),
        .frame_valid (frame_valid),
        .seg_error   (seg_error),
        .an_error    (an_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 frame, 1 seg_error, 2 an_error
        logic [15:0] dv;
        logic [13:0] tv;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [6:0] seg_tab [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] dv, input logic [13:0] tv);
        exp_t e;
        e.kind = kind;
        e.dv   = dv;
        e.tv   = tv;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int slot, input int val, input int n);
        logic [3:0] a;
        a = 4'b0001 << slot;
        hold(~a, seg_tab[val], n);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_digit_value"}, digit_value, 16'h0000);
        chk({tag, "_time_value"},  16'(time_value), 16'h0000);
        chk({tag, "_frame_valid"}, 16'(frame_valid), 16'h0000);
        chk({tag, "_seg_error"},   16'(seg_error), 16'h0000);
        chk({tag, "_an_error"},    16'(an_error), 16'h0000);
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && (frame_valid || seg_error || an_error)) begin
            int   kind;
            exp_t e;
            kind = frame_valid ? 0 : (seg_error ? 1 : 2);
            $display("EVENT kind=%0d digit_value=%04h time_value=%0d", kind, digit_value, time_value);
            chk("pulse_exclusive", 16'(int'(frame_valid) + int'(seg_error) + int'(an_error)), 16'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual_kind=%0d required=none", kind);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", 16'(kind), 16'(e.kind));
                chk("digit_value", digit_value, e.dv);
                chk("time_value", 16'(time_value), 16'(e.tv));
            end
        end
    end

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        rst_n = 1'b0;
        an    = 4'b1111;
        seg   = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        hold(4'b1111, 7'b1111111, 10);

        // Frame 1259, ones first.
        push(0, 16'h1259, 14'd1259);
        digit(0, 9, 20);
        digit(1, 5, 20);
        digit(2, 2, 20);
        digit(3, 1, 20);
        hold(4'b1111, 7'b1111111, 20);

        // Too-short glitch on the ones slot must not count towards the frame.
        hold(4'b1110, 7'b0100100, 5);
        hold(4'b1111, 7'b1111111, 20);
        digit(1, 4, 20);
        digit(2, 3, 20);
        digit(3, 7, 20);
        hold(4'b1111, 7'b1111111, 20);
        push(0, 16'h7348, 14'd7348);
        digit(0, 8, 20);
        hold(4'b1111, 7'b1111111, 20);

        // Errors clear the partial mask and leave the outputs alone.
        digit(0, 6, 20);
        push(1, 16'h7348, 14'd7348);
        hold(4'b1101, 7'b1111111, 10);
        hold(4'b1111, 7'b1111111, 20);
        push(2, 16'h7348, 14'd7348);
        hold(4'b1100, 7'b1000000, 10);
        hold(4'b1111, 7'b1111111, 20);
        digit(1, 0, 20);
        digit(2, 0, 20);
        digit(3, 0, 20);
        hold(4'b1111, 7'b1111111, 20);

        // Mid-frame reset discards the captured tens/hundreds/thousands.
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset_a");
        hold(4'b1111, 7'b1111111, 3);
        check_idle_outputs("midreset_b");
        rst_n = 1'b1;
        hold(4'b1111, 7'b1111111, 10);
        digit(0, 5, 20);
        hold(4'b1111, 7'b1111111, 20);
        push(0, 16'h2045, 14'd2045);
        digit(1, 4, 20);
        digit(2, 0, 20);
        digit(3, 2, 20);
        hold(4'b1111, 7'b1111111, 20);

        // Back-to-back frames at both ends of the range.
        push(0, 16'h0000, 14'd0);
        for (int i = 0; i < 4; i++) digit(i, 0, 20);
        push(0, 16'h9999, 14'd9999);
        for (int i = 0; i < 4; i++) digit(i, 9, 20);
        hold(4'b1111, 7'b1111111, 30);

        chk("pending_events", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
